// File: rtl/mmul_index_sequencer.sv
// Loop-index generator for the matrix-multiply datapath: walks every (i, j, k)
// tuple of C[i][j] += A[i][k]*B[k][j] under a valid/advance handshake.
module mmul_index_sequencer #(
  parameter int RA         = 1,
  parameter int CA         = 1,
  parameter int RB         = 1,
  parameter int CB         = 1,
  parameter int IDX_W      = 32,
  parameter int LOOP_ORDER = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             advance,
  output logic             valid,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] k,
  output logic             first_k,
  output logic             last_k,
  output logic             busy,
  output logic             done,
  output logic             completed
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MAX_AB  = (RA > RB) ? RA : RB;
  localparam int MAX_DIM = (MAX_AB > CB) ? MAX_AB : CB;

  localparam logic [IDX_W-1:0] I_LAST   = IDX_W'(RA - 1);
  localparam logic [IDX_W-1:0] J_LAST   = IDX_W'(CB - 1);
  localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(RB - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Parameter sanity: a bad configuration must never reach synthesis.
  generate
    if (CA != RB) begin : g_err_inner_dim
      $error("mmul_index_sequencer: CA (%0d) must equal RB (%0d)", CA, RB);
    end
    if (RA < 1 || CA < 1 || RB < 1 || CB < 1) begin : g_err_zero_dim
      $error("mmul_index_sequencer: all matrix dimensions must be >= 1");
    end
    if (LOOP_ORDER != 0 && LOOP_ORDER != 1) begin : g_err_order
      $error("mmul_index_sequencer: LOOP_ORDER must be 0 or 1");
    end
    if (IDX_W < 1) begin : g_err_width
      $error("mmul_index_sequencer: IDX_W must be >= 1");
    end else if (IDX_W < 31) begin : g_chk_width
      if (MAX_DIM - 1 >= (1 << IDX_W)) begin : g_err_range
        $error("mmul_index_sequencer: IDX_W too narrow for largest index");
      end
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             done_q, done_d;
  logic             completed_q, completed_d;

  logic i_at_last;
  logic j_at_last;
  logic k_at_last;
  logic at_final;

  assign i_at_last = (i_q == I_LAST);
  assign j_at_last = (j_q == J_LAST);
  assign k_at_last = (k_q == K_LAST);
  // The final tuple is the same corner for both loop orders.
  assign at_final  = i_at_last && j_at_last && k_at_last;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      done_q      <= 1'b0;
      completed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      done_q      <= done_d;
      completed_q <= completed_d;
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    done_d      = 1'b0;
    completed_d = completed_q;

    if (abort) begin
      state_d     = ST_IDLE;
      i_d         = IDX_ZERO;
      j_d         = IDX_ZERO;
      k_d         = IDX_ZERO;
      completed_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_RUN;
            i_d         = IDX_ZERO;
            j_d         = IDX_ZERO;
            k_d         = IDX_ZERO;
            completed_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (advance) begin
            if (at_final) begin
              state_d     = ST_IDLE;
              i_d         = IDX_ZERO;
              j_d         = IDX_ZERO;
              k_d         = IDX_ZERO;
              done_d      = 1'b1;
              completed_d = 1'b1;
            end else if (LOOP_ORDER == 0) begin
              // k innermost, carry into j, then i.
              if (k_at_last) begin
                k_d = IDX_ZERO;
                if (j_at_last) begin
                  j_d = IDX_ZERO;
                  i_d = i_q + IDX_ONE;
                end else begin
                  j_d = j_q + IDX_ONE;
                end
              end else begin
                k_d = k_q + IDX_ONE;
              end
            end else begin
              // j innermost, carry into k, then i.
              if (j_at_last) begin
                j_d = IDX_ZERO;
                if (k_at_last) begin
                  k_d = IDX_ZERO;
                  i_d = i_q + IDX_ONE;
                end else begin
                  k_d = k_q + IDX_ONE;
                end
              end else begin
                j_d = j_q + IDX_ONE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    valid     = (state_q == ST_RUN);
    busy      = (state_q == ST_RUN);
    i         = i_q;
    j         = j_q;
    k         = k_q;
    first_k   = valid && (k_q == IDX_ZERO);
    last_k    = valid && k_at_last;
    done      = done_q;
    completed = completed_q;
  end

endmodule

// File: tb/tb_mmul_index_sequencer.sv
// Bench for mmul_index_sequencer: four instances cover both loop orders,
// a stall-heavy 3x4x2 walk with abort/reset, and the degenerate 1x1x1 case.
module tb_mmul_index_sequencer;

  localparam int W = 8;

  typedef struct packed {
    logic         v;
    logic         busy;
    logic         fk;
    logic         lk;
    logic         dn;
    logic         cm;
    logic [W-1:0] i;
    logic [W-1:0] j;
    logic [W-1:0] k;
  } obs_t;

  typedef struct {
    logic st;
    logic ab;
    logic adv;
    obs_t exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0]   start_s, abort_s, adv_s;
  logic [3:0]   valid_w, busy_w, fk_w, lk_w, done_w, cm_w;
  logic [W-1:0] i_w [4];
  logic [W-1:0] j_w [4];
  logic [W-1:0] k_w [4];
  obs_t         obs [4];

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mmul_index_sequencer #(.RA(2), .CA(3), .RB(3), .CB(2), .IDX_W(W), .LOOP_ORDER(0)) u_ord0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]), .advance(adv_s[0]),
    .valid(valid_w[0]), .i(i_w[0]), .j(j_w[0]), .k(k_w[0]), .first_k(fk_w[0]), .last_k(lk_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .completed(cm_w[0]));

  mmul_index_sequencer #(.RA(2), .CA(3), .RB(3), .CB(2), .IDX_W(W), .LOOP_ORDER(1)) u_ord1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]), .advance(adv_s[1]),
    .valid(valid_w[1]), .i(i_w[1]), .j(j_w[1]), .k(k_w[1]), .first_k(fk_w[1]), .last_k(lk_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .completed(cm_w[1]));

  mmul_index_sequencer #(.RA(3), .CA(2), .RB(2), .CB(4), .IDX_W(W), .LOOP_ORDER(0)) u_342 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]), .advance(adv_s[2]),
    .valid(valid_w[2]), .i(i_w[2]), .j(j_w[2]), .k(k_w[2]), .first_k(fk_w[2]), .last_k(lk_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .completed(cm_w[2]));

  mmul_index_sequencer #(.RA(1), .CA(1), .RB(1), .CB(1), .IDX_W(W), .LOOP_ORDER(0)) u_111 (
    .clk(clk), .rst_n(rst_n), .start(start_s[3]), .abort(abort_s[3]), .advance(adv_s[3]),
    .valid(valid_w[3]), .i(i_w[3]), .j(j_w[3]), .k(k_w[3]), .first_k(fk_w[3]), .last_k(lk_w[3]),
    .busy(busy_w[3]), .done(done_w[3]), .completed(cm_w[3]));

  for (genvar g = 0; g < 4; g++) begin : g_obs
    assign obs[g] = {valid_w[g], busy_w[g], fk_w[g], lk_w[g], done_w[g], cm_w[g],
                     i_w[g], j_w[g], k_w[g]};
  end

  function automatic obs_t mk(logic v, logic b, logic fk, logic lk, logic dn, logic cm,
                              int ii, int jj, int kk);
    obs_t r;
    r.v = v; r.busy = b; r.fk = fk; r.lk = lk; r.dn = dn; r.cm = cm;
    r.i = W'(ii); r.j = W'(jj); r.k = W'(kk);
    return r;
  endfunction

  function automatic obs_t tup(int ii, int jj, int kk, int kmax);
    return mk(1'b1, 1'b1, kk == 0, kk == kmax, 1'b0, 1'b0, ii, jj, kk);
  endfunction

  function automatic obs_t idle(logic cm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cm, 0, 0, 0);
  endfunction

  function automatic obs_t done_obs();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
  endfunction

  function automatic vec_t vec(logic st, logic ab, logic adv, obs_t e);
    vec_t r;
    r.st = st; r.ab = ab; r.adv = adv; r.exp = e;
    return r;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got v=%0b busy=%0b fk=%0b lk=%0b done=%0b cmp=%0b ijk=(%0d,%0d,%0d) need v=%0b busy=%0b fk=%0b lk=%0b done=%0b cmp=%0b ijk=(%0d,%0d,%0d)",
               name, act.v, act.busy, act.fk, act.lk, act.dn, act.cm, act.i, act.j, act.k,
               exp.v, exp.busy, exp.fk, exp.lk, exp.dn, exp.cm, exp.i, exp.j, exp.k);
    end
  endtask

  task automatic drive(int u, logic st, logic ab, logic adv);
    start_s[u] = st;
    abort_s[u] = ab;
    adv_s[u]   = adv;
  endtask

  // Each row: compare outputs at the falling edge, then apply that row's inputs.
  task automatic run_table(int u, string tag);
    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, r), obs[u], tbl[r].exp);
      drive(u, tbl[r].st, tbl[r].ab, tbl[r].adv);
    end
  endtask

  task automatic push_tail();
    tbl.push_back(vec(1'b0, 1'b0, 1'b0, done_obs()));
    tbl.push_back(vec(1'b0, 1'b0, 1'b0, idle(1'b1)));
    tbl.push_back(vec(1'b0, 1'b1, 1'b0, idle(1'b1)));
    tbl.push_back(vec(1'b0, 1'b0, 1'b0, idle(1'b0)));
  endtask

  initial begin
    int  n;
    bit  got_done;
    logic adv;

    start_s = '0;
    abort_s = '0;
    adv_s   = '0;

    #12;
    for (int u = 0; u < 4; u++) check($sformatf("reset_state%0d", u), obs[u], idle(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Order 0: k innermost; one stall with start asserted mid-run.
    tbl.delete();
    tbl.push_back(vec(1'b1, 1'b0, 1'b1, idle(1'b0)));
    for (int ii = 0; ii < 2; ii++)
      for (int jj = 0; jj < 2; jj++)
        for (int kk = 0; kk < 3; kk++) begin
          if (ii == 0 && jj == 1 && kk == 0)
            tbl.push_back(vec(1'b1, 1'b0, 1'b0, tup(ii, jj, kk, 2)));
          tbl.push_back(vec(1'b0, 1'b0, 1'b1, tup(ii, jj, kk, 2)));
        end
    push_tail();
    run_table(0, "ord0");

    // Order 1: j innermost, k middle.
    tbl.delete();
    tbl.push_back(vec(1'b1, 1'b0, 1'b1, idle(1'b0)));
    for (int ii = 0; ii < 2; ii++)
      for (int kk = 0; kk < 3; kk++)
        for (int jj = 0; jj < 2; jj++)
          tbl.push_back(vec(1'b0, 1'b0, 1'b1, tup(ii, jj, kk, 2)));
    push_tail();
    run_table(1, "ord1");

    // Random advance over 3x4x2: indices must hold on stalls, 24 tuples, one done.
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 1'b0);
    n = 0;
    got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      @(negedge clk);
      if (n < 24) begin
        check($sformatf("rand_tuple%0d", n), obs[2], tup(n / 8, (n / 2) % 4, n % 2, 1));
        adv = 1'($urandom_range(0, 1));
        drive(2, 1'b0, 1'b0, adv);
        if (adv) n++;
      end else begin
        check("rand_done", obs[2], done_obs());
        got_done = 1'b1;
        drive(2, 1'b0, 1'b0, 1'b0);
      end
    end
    if (!got_done) begin
      total++;
      bad++;
      $display("FAIL rand_timeout: got accepted=%0d without done, need 24 then done", n);
    end
    @(negedge clk);
    check("rand_after", obs[2], idle(1'b1));

    // Abort after 5 accepts, with start also high (ignored mid-run and during abort).
    drive(2, 1'b1, 1'b0, 1'b1);
    for (int t = 0; t <= 5; t++) begin
      @(negedge clk);
      check($sformatf("abort_tuple%0d", t), obs[2], tup(t / 8, (t / 2) % 4, t % 2, 1));
      if (t == 5) drive(2, 1'b1, 1'b1, 1'b1);
      else        drive(2, t == 2, 1'b0, 1'b1);
    end
    @(negedge clk);
    check("abort_idle", obs[2], idle(1'b0));
    drive(2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("abort_no_restart", obs[2], idle(1'b0));

    // 1x1x1, then a restart in the done cycle.
    drive(3, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("one_tuple", obs[3], tup(0, 0, 0, 0));
    drive(3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("one_done", obs[3], done_obs());
    drive(3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("one_restart", obs[3], tup(0, 0, 0, 0));
    drive(3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("one_stall", obs[3], tup(0, 0, 0, 0));
    drive(3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("one_done2", obs[3], done_obs());
    drive(3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("one_after", obs[3], idle(1'b1));

    // Asynchronous reset while presenting tuple (1,0,1).
    drive(2, 1'b1, 1'b0, 1'b1);
    for (int t = 0; t <= 9; t++) begin
      @(negedge clk);
      check($sformatf("rst_tuple%0d", t), obs[2], tup(t / 8, (t / 2) % 4, t % 2, 1));
      drive(2, 1'b0, 1'b0, t != 9);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_342", obs[2], idle(1'b0));
    check("async_reset_111", obs[3], idle(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("post_reset_t0", obs[2], tup(0, 0, 0, 1));
    drive(2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("post_reset_t1", obs[2], tup(0, 0, 1, 1));
    drive(2, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
